// File: rtl/apb_node_reg.sv
// apb_node_reg: registered APB 1-to-NB_SLAVE demux with runtime address map; ports: clk, rst, upstream p*_i/p*_o slave side, downstream p*_o/p*_i master side, start_addr_i/end_addr_i map; optional APB_NODE_TIMEOUT_EN access watchdog
module apb_node_reg #(
  parameter int NB_SLAVE = 10,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [APB_ADDR_WIDTH-1:0]          paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]          pwdata_i,
  input  logic                               pwrite_i,
  input  logic                               psel_i,
  input  logic                               penable_i,
  output logic [APB_DATA_WIDTH-1:0]          prdata_o,
  output logic                               pready_o,
  output logic                               pslverr_o,
  output logic [APB_ADDR_WIDTH-1:0]          paddr_o,
  output logic [APB_DATA_WIDTH-1:0]          pwdata_o,
  output logic                               pwrite_o,
  output logic [NB_SLAVE-1:0]                psel_o,
  output logic                               penable_o,
  input  logic [NB_SLAVE*APB_DATA_WIDTH-1:0] prdata_i,
  input  logic [NB_SLAVE-1:0]                pready_i,
  input  logic [NB_SLAVE-1:0]                pslverr_i,
  input  logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_SLAVE*APB_ADDR_WIDTH-1:0] end_addr_i
);
  localparam int IW = NB_SLAVE > 1 ? $clog2(NB_SLAVE) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, ERR} state_e;
  state_e state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic write_q, write_d, err_q, err_d, hit;
  logic [IW-1:0] idx_q, idx_d, hit_idx;
`ifdef APB_NODE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif
  // descending scan so the lowest matching slot is the last one written
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int k = NB_SLAVE - 1; k >= 0; k--)
      if (start_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] <= paddr_i &&
          paddr_i <= end_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) begin
        hit = 1'b1;
        hit_idx = IW'(k);
      end
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    idx_d = idx_q;
    rdata_d = rdata_q;
    err_d = err_q;
`ifdef APB_NODE_TIMEOUT_EN
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: if (psel_i && !penable_i) begin
        addr_d = paddr_i;
        wdata_d = pwdata_i;
        write_d = pwrite_i;
        idx_d = hit_idx;
        state_d = hit ? SETUP : ERR;
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_NODE_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      ACCESS: if (pready_i[idx_q]) begin
        rdata_d = prdata_i[idx_q*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        err_d = pslverr_i[idx_q];
        state_d = RESP;
      end
`ifdef APB_NODE_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        rdata_d = '0;
        err_d = 1'b1;
        state_d = RESP;
      end else cnt_d = cnt_q + 1'b1;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      idx_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
`ifdef APB_NODE_TIMEOUT_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      idx_q <= idx_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
`ifdef APB_NODE_TIMEOUT_EN
      cnt_q <= cnt_d;
`endif
    end
  end
  assign paddr_o = addr_q;
  assign pwdata_o = wdata_q;
  assign pwrite_o = write_q;
  assign psel_o = (state_q == SETUP || state_q == ACCESS) ? NB_SLAVE'(1) << idx_q : '0;
  assign penable_o = state_q == ACCESS;
  assign pready_o = state_q == RESP || state_q == ERR;
  assign pslverr_o = state_q == ERR || (state_q == RESP && err_q);
  assign prdata_o = state_q == RESP ? rdata_q : '0;
endmodule
